// File: rtl/write_grant_arbiter.sv
// write_grant_arbiter: picks one ready port by highest priority, breaking ties
// round-robin from rr_ptr, and holds a one-hot grant until the SRAM write
// controller pulses done. All outputs come straight from flops.
module write_grant_arbiter #(
  parameter  int num_of_ports   = 16,
  parameter  int priority_width = 3,
  localparam int port_idx_width = $clog2(num_of_ports)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [num_of_ports*priority_width-1:0] priority_in,
  input  logic [num_of_ports-1:0]                ready,
  input  logic                                   done,
  output logic [num_of_ports-1:0]                grant,
  output logic                                   grant_valid,
  output logic [port_idx_width-1:0]              grant_port,
  output logic [priority_width-1:0]              grant_priority
);

  typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

  state_t                    state, state_nxt;
  logic [port_idx_width-1:0] rr_ptr;

  logic                      win_found;
  logic [port_idx_width-1:0] win_idx;
  logic [priority_width-1:0] win_pri;
  logic [port_idx_width-1:0] idx;
  logic [priority_width-1:0] cand_pri;

  logic                      load_grant;
  logic                      clear_grant;

  // Priority search starting at rr_ptr; strict '>' keeps the first tied
  // candidate in scan order, which gives the round-robin tie break.
  // Index arithmetic wraps naturally since num_of_ports is a power of 2.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_pri   = '0;
    idx       = '0;
    cand_pri  = '0;
    for (int k = 0; k < num_of_ports; k++) begin
      idx      = rr_ptr + port_idx_width'(k);
      cand_pri = priority_in[idx*priority_width +: priority_width];
      if (ready[idx] && (!win_found || cand_pri > win_pri)) begin
        win_found = 1'b1;
        win_idx   = idx;
        win_pri   = cand_pri;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: IDLE waits one cycle for priority_in to settle before ARB.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|ready) state_nxt = ARB;
      ARB:     state_nxt = win_found ? GRANT : IDLE;
      GRANT:   if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output controls: load on a successful ARB, clear on done while granting.
  // done outside GRANT is deliberately ignored.
  always_comb begin
    load_grant  = (state == ARB) && win_found;
    clear_grant = (state == GRANT) && done;
  end

  // Registered grant outputs and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant          <= '0;
      grant_valid    <= 1'b0;
      grant_port     <= '0;
      grant_priority <= '0;
      rr_ptr         <= '0;
    end else if (load_grant) begin
      grant          <= num_of_ports'(1) << win_idx;
      grant_valid    <= 1'b1;
      grant_port     <= win_idx;
      grant_priority <= win_pri;
    end else if (clear_grant) begin
      grant          <= '0;
      grant_valid    <= 1'b0;
      grant_port     <= '0;
      grant_priority <= '0;
      rr_ptr         <= grant_port + port_idx_width'(1);
    end
  end

endmodule

// File: tb/tb_write_grant_arbiter.sv
// Directed bench for write_grant_arbiter with hand-computed expectations.
module tb_write_grant_arbiter;

  localparam int N  = 16;
  localparam int PW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*PW-1:0] priority_in;
  logic [N-1:0]    ready;
  logic            done;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [3:0]      grant_port;
  logic [PW-1:0]   grant_priority;

  int n_tests = 0;
  int n_fail  = 0;

  write_grant_arbiter #(.num_of_ports(N), .priority_width(PW)) dut (
    .clk(clk), .rst(rst), .priority_in(priority_in), .ready(ready), .done(done),
    .grant(grant), .grant_valid(grant_valid), .grant_port(grant_port),
    .grant_priority(grant_priority)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [N-1:0] g, input logic v,
                         input logic [3:0] p, input logic [PW-1:0] pr);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(v));
    chk({tag, ".port"},  32'(grant_port), 32'(p));
    chk({tag, ".pri"},   32'(grant_priority), 32'(pr));
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pri(input int p, input int v);
    priority_in[p*PW +: PW] = PW'(v);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ready = '0; done = 1'b0; priority_in = '0;
    tick(2);
    rst = 1'b0;
    chk_out("reset", 16'h0, 1'b0, 4'd0, 3'd0);

    // Highest priority wins: port4 (pri5) over port1 (pri2).
    set_pri(1, 2); set_pri(4, 5); ready = 16'h0012;
    tick();
    chk_out("t2.arb", 16'h0, 1'b0, 4'd0, 3'd0);
    tick();
    chk_out("t2.grant", 16'h0010, 1'b1, 4'd4, 3'd5);
    ready = '0;
    tick(3);
    chk_out("t2.hold", 16'h0010, 1'b1, 4'd4, 3'd5);
    pulse_done();
    chk_out("t2.clear", 16'h0, 1'b0, 4'd0, 3'd0);

    // rr_ptr should now be 5: tie between 4 and 6 goes to 6.
    priority_in = '0; set_pri(4, 1); set_pri(6, 1); ready = 16'h0050;
    tick(2);
    chk_out("t2.rr5", 16'h0040, 1'b1, 4'd6, 3'd1);
    ready = '0;
    pulse_done();

    // Reset mid-grant on port2 (rr_ptr was 7), then a stray done.
    priority_in = '0; set_pri(2, 1); ready = 16'h0004;
    tick(2);
    chk_out("t1.grant", 16'h0004, 1'b1, 4'd2, 3'd1);
    ready = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("t1.reset", 16'h0, 1'b0, 4'd0, 3'd0);
    pulse_done();
    chk_out("t1.done_idle", 16'h0, 1'b0, 4'd0, 3'd0);

    // Tie 0 vs 8 from rr_ptr=0 alternates with ready held.
    priority_in = '0; set_pri(0, 3); set_pri(8, 3); ready = 16'h0101;
    tick(2);
    chk_out("t3.first", 16'h0001, 1'b1, 4'd0, 3'd3);
    pulse_done();
    chk_out("t3.clear", 16'h0, 1'b0, 4'd0, 3'd0);
    tick();
    chk("t3.arb_gap", 32'(grant_valid), 32'd0);
    tick();
    chk_out("t3.second", 16'h0100, 1'b1, 4'd8, 3'd3);
    pulse_done();
    tick(2);
    chk_out("t3.third", 16'h0001, 1'b1, 4'd0, 3'd3);
    ready = '0;
    pulse_done();

    // Wrap: port15 wins, rr_ptr returns to 0, tie 0 vs 15 goes to 0.
    priority_in = '0; set_pri(15, 2); ready = 16'h8000;
    tick(2);
    chk_out("t4.p15", 16'h8000, 1'b1, 4'd15, 3'd2);
    ready = '0;
    pulse_done();
    set_pri(0, 2); ready = 16'h8001;
    tick(2);
    chk_out("t4.wrap", 16'h0001, 1'b1, 4'd0, 3'd2);
    ready = '0;
    pulse_done();

    // Ready vanishes in ARB: no grant. rr_ptr is 1 now.
    priority_in = '0; ready = 16'h0001;
    tick();
    ready = '0;
    tick();
    chk_out("t5.nogrant", 16'h0, 1'b0, 4'd0, 3'd0);
    tick();
    chk_out("t5.idle", 16'h0, 1'b0, 4'd0, 3'd0);
    pulse_done();
    // rr_ptr still 1: tie 0 vs 2 goes to 2.
    set_pri(0, 4); set_pri(2, 4); ready = 16'h0005;
    tick(2);
    chk_out("t5.rr1", 16'h0004, 1'b1, 4'd2, 3'd4);
    ready = '0;
    pulse_done();

    // Grant on port2 ignores ready changes; port7 follows after done.
    priority_in = '0; set_pri(2, 1); ready = 16'h0004;
    tick(2);
    chk_out("t6.grant2", 16'h0004, 1'b1, 4'd2, 3'd1);
    ready = 16'h0080; set_pri(7, 7);
    tick(2);
    chk_out("t6.hold", 16'h0004, 1'b1, 4'd2, 3'd1);
    pulse_done();
    chk_out("t6.clear", 16'h0, 1'b0, 4'd0, 3'd0);
    tick();
    chk("t6.arb_gap", 32'(grant), 32'd0);
    tick();
    chk_out("t6.grant7", 16'h0080, 1'b1, 4'd7, 3'd7);
    ready = '0;
    pulse_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
